// File: rtl/tone_sequencer_voice_if.sv
// Command channel for the tone sequencer voice.
// Carries note index and duration over a valid/ready handshake.
interface tone_sequencer_voice_if #(
  parameter int NOTE_BITS = 4,
  parameter int DUR_BITS  = 12
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [NOTE_BITS-1:0] cmd_note;
  logic [DUR_BITS-1:0]  cmd_dur;

  modport master (
    output cmd_valid,
    output cmd_note,
    output cmd_dur,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_note,
    input  cmd_dur,
    output cmd_ready
  );
endinterface

// File: rtl/tone_sequencer_voice.sv
// Single-voice square-wave tone generator driven by (note, duration) commands.
// Ports: externalClock/resetN, cmd (slave), abort in; music, busy, done out.
module tone_sequencer_voice #(
  parameter int CLK_HZ    = 50000000,
  parameter int NOTE_BITS = 4,
  parameter int DUR_BITS  = 12,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 10
) (
  input  logic                  externalClock,
  input  logic                  resetN,
  tone_sequencer_voice_if.slave cmd,
  input  logic                  abort,
  output logic                  music,
  output logic                  busy,
  output logic                  done
);

  // Half period in clocks for chromatic note i, 9 = A4 = 440 Hz.
  function automatic int half_calc(input int i);
    real f;
    f = 440.0 * (2.0 ** ((real'(i) - 9.0) / 12.0));
    return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
  endfunction

  // C4 is the lowest note, so it sets the tone counter width.
  localparam int MAXHALF = half_calc(0);
  localparam int TW = (MAXHALF > 1) ? $clog2(MAXHALF) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int KW = (DUR_BITS > GW) ? DUR_BITS : GW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NOTE_BITS-1:0] note_q, note_d;
  logic [KW-1:0]        tick_q, tick_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [TW-1:0]        tone_q, tone_d;
  logic                 music_q, music_d;
  logic                 done_q, done_d;

  logic [TW-1:0] half_tbl [16];

  for (genvar g = 0; g < 16; g++) begin : g_tbl
    localparam int H = half_calc(g);
    assign half_tbl[g] = TW'(H - 1);
  end

  logic [TW-1:0] half_m1;
  logic          rest;
  logic          accept;
  logic          pre_wrap;
  logic          last_tick;

  assign half_m1   = half_tbl[note_q];
  assign rest      = (note_q == NOTE_BITS'(15));
  assign accept    = cmd.cmd_valid && (state_q == IDLE) && !abort;
  assign pre_wrap  = (pre_q == PW'(TICK_DIV - 1));
  assign last_tick = pre_wrap && (tick_q == KW'(1));

  always_ff @(posedge externalClock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      note_q  <= '0;
      tick_q  <= '0;
      pre_q   <= '0;
      tone_q  <= '0;
      music_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      tick_q  <= tick_d;
      pre_q   <= pre_d;
      tone_q  <= tone_d;
      music_q <= music_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    tick_d  = tick_q;
    pre_d   = pre_q;
    tone_d  = tone_q;
    music_d = music_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        music_d = 1'b0;
        if (accept) begin
          note_d = cmd.cmd_note;
          pre_d  = '0;
          tone_d = '0;
          if (cmd.cmd_dur != '0) begin
            state_d = PLAY;
            tick_d  = KW'(cmd.cmd_dur);
          end else if (GAP_TICKS != 0) begin
            state_d = GAP;
            tick_d  = KW'(GAP_TICKS);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PLAY: begin
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        if (pre_wrap) tick_d = tick_q - 1'b1;
        if (tone_q == half_m1) begin
          tone_d = '0;
          if (!rest) music_d = !music_q;
        end else begin
          tone_d = tone_q + 1'b1;
        end
        if (last_tick) begin
          music_d = 1'b0;
          tone_d  = '0;
          pre_d   = '0;
          if (GAP_TICKS != 0) begin
            state_d = GAP;
            tick_d  = KW'(GAP_TICKS);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        music_d = 1'b0;
        pre_d   = pre_wrap ? '0 : pre_q + 1'b1;
        if (pre_wrap) tick_d = tick_q - 1'b1;
        if (last_tick) begin
          state_d = IDLE;
          pre_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a pending completion.
    if (abort) begin
      state_d = IDLE;
      music_d = 1'b0;
      done_d  = 1'b0;
      tone_d  = '0;
      pre_d   = '0;
      tick_d  = '0;
    end
  end

  always_comb begin
    cmd.cmd_ready = (state_q == IDLE);
    busy          = (state_q != IDLE);
    music         = music_q;
    done          = done_q;
  end

endmodule
